// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serializes sel/seg into two cascaded 74HC595s, one 14-bit frame plus latch pulse per period
// Optional macro HC595_OE_EN: hold oe high until the first complete frame has been latched.
module hc595_ctrl #(
    parameter int HALF_PER = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    output logic       shcp,
    output logic       stcp,
    output logic       ds,
    output logic       oe
);
    localparam int FRAME_BITS = 14;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [8:0] DIV_HALF = 9'(HALF_PER);
    localparam logic [8:0] DIV_LAST = 9'(2 * HALF_PER - 1);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    logic [1:0]            state, nxt_state;
    logic [8:0]            div_cnt, nxt_div;
    logic [3:0]            bit_cnt, nxt_bit;
    logic [FRAME_BITS-1:0] sr, frame;
    logic                  is_load, wrap, adv_bit;

    assign frame   = {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6], seg[7], sel};
    assign is_load = state != SHIFT && state != LATCH;
    assign wrap    = div_cnt == DIV_LAST;
    assign adv_bit = state == SHIFT && wrap && bit_cnt != LAST_BIT;

    // next-state sequencing; an unused state code behaves like LOAD
    always_comb begin
        nxt_div   = (is_load || wrap) ? 9'd0 : div_cnt + 9'd1;
        nxt_bit   = is_load ? 4'd0 : adv_bit ? bit_cnt + 4'd1 : bit_cnt;
        nxt_state = is_load ? SHIFT :
                    !wrap ? state :
                    state == LATCH ? LOAD :
                    bit_cnt == LAST_BIT ? LATCH : SHIFT;
    end

    // state, counters, shift register and registered 595 pins derived from the next state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= LOAD;
            div_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            ds      <= 1'b0;
        end else begin
            state   <= nxt_state;
            div_cnt <= nxt_div;
            bit_cnt <= nxt_bit;
            shcp    <= nxt_state == SHIFT && nxt_div >= DIV_HALF;
            stcp    <= nxt_state == LATCH && nxt_div >= DIV_HALF;
            if (is_load) begin
                sr <= frame;
                ds <= frame[0];
            end else if (adv_bit) begin
                sr <= {1'b0, sr[FRAME_BITS-1:1]};
                ds <= sr[1];
            end
        end
    end

    // output enable: immediate, or deferred until the first latch completes
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            oe <= 1'b1;
        end else begin
`ifdef HC595_OE_EN
            if (state == LATCH && wrap) oe <= 1'b0;
`else
            oe <= 1'b0;
`endif
        end
    end
endmodule
